// File: rtl/jt12_slot_sched.sv
// jt12_slot_sched: slot counter plus in-order write queue that patches values into a recirculating delay line.
module jt12_slot_sched #(
   parameter int width  = 5,
   parameter int stages = 24,
   parameter int depth  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_en,
   input  logic             wr_req,
   input  logic [4:0]       wr_slot,
   input  logic [width-1:0] wr_data,
   output logic             wr_ready,
   output logic             wr_err,
   output logic             busy,
   output logic [4:0]       slot,
   output logic [2:0]       ch,
   output logic [1:0]       op,
   output logic             zero,
   input  logic [width-1:0] sh_dout,
   output logic [width-1:0] sh_din,
   output logic             upd
);
   localparam int aw = $clog2(depth);
   localparam logic [aw:0] full_cnt = (aw+1)'(depth);
   logic [width+4:0] mem [depth];
   logic [aw-1:0] rd_ptr, wr_ptr;
   logic [aw:0] cnt;
   logic [4:0] head_slot;
   logic [width-1:0] head_data;
   logic wrap, bad, take, push, pop;
   assign {head_slot, head_data} = mem[rd_ptr];
   assign busy = cnt != '0;
   assign wr_ready = cnt != full_cnt;
   assign zero = slot == 5'd0;
   assign wrap = slot == 5'(stages - 1);
   assign bad = {1'b0, wr_slot} >= 6'(stages);
   assign pop = clk_en & busy & (head_slot == slot) & ~rst;
   // a pop frees the head entry on the same edge, so a full queue can still take a write
   assign take = wr_req & ~rst & (wr_ready | pop);
   assign push = take & ~bad;
   assign upd = pop;
   assign sh_din = rst ? '0 : pop ? head_data : sh_dout;
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {wr_slot, wr_data};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         slot   <= '0;
         ch     <= '0;
         op     <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
         wr_err <= 1'b0;
      end else begin
         wr_err <= take & bad;
         if (clk_en) begin
            slot <= wrap ? 5'd0 : slot + 5'd1;
            ch   <= (wrap || ch == 3'd5) ? 3'd0 : ch + 3'd1;
            op   <= wrap ? 2'd0 : (ch == 3'd5 && op != 2'd3) ? op + 2'd1 : op;
         end
         if (push) wr_ptr <= wr_ptr + aw'(1);
         if (pop) rd_ptr <= rd_ptr + aw'(1);
         if (push != pop) cnt <= push ? cnt + (aw+1)'(1) : cnt - (aw+1)'(1);
      end
   end
endmodule

// File: tb/tb_jt12_slot_sched.sv
// tb_jt12_slot_sched: scoreboard bench with a 24-stage delay line attached to the scheduler.
module tb_jt12_slot_sched;
   logic clk = 1'b0, rst = 1'b1, clk_en = 1'b1, wr_req = 1'b0;
   logic [4:0] wr_slot = '0, wr_data = '0;
   logic wr_ready, wr_err, busy, zero, upd;
   logic [4:0] slot, sh_dout, sh_din;
   logic [2:0] ch;
   logic [1:0] op;
   logic [4:0] sh [24];
   int vectors = 0, miscompares = 0;
   typedef struct packed {logic [4:0] s; logic [4:0] d;} ent_t;
   ent_t sb[$];
   logic [4:0] ring [24];
   int m_slot = 0, rcnt = 0;
   bit ring_ok = 0, m_err = 0, go = 0;

   jt12_slot_sched dut (
      .clk(clk), .rst(rst), .clk_en(clk_en), .wr_req(wr_req), .wr_slot(wr_slot),
      .wr_data(wr_data), .wr_ready(wr_ready), .wr_err(wr_err), .busy(busy),
      .slot(slot), .ch(ch), .op(op), .zero(zero), .sh_dout(sh_dout),
      .sh_din(sh_din), .upd(upd)
   );

   always #5 clk = ~clk;

   assign sh_dout = sh[23];
   always @(posedge clk) if (clk_en) begin
      sh[0] <= sh_din;
      for (int i = 1; i < 24; i++) sh[i] <= sh[i-1];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // checks DUT against the scoreboard, then advances the scoreboard past the coming edge
   always @(negedge clk) if (go) begin
      bit m, acc;
      logic [4:0] din;
      m = clk_en && !rst && sb.size() > 0 && sb[0].s == m_slot;
      din = rst ? 5'd0 : m ? sb[0].d : sh_dout;
      chk("slot", slot, m_slot);
      chk("ch", ch, m_slot % 6);
      chk("op", op, m_slot / 6 > 3 ? 3 : m_slot / 6);
      chk("zero", zero, m_slot == 0);
      chk("busy", busy, sb.size() > 0);
      chk("wr_ready", wr_ready, sb.size() < 4);
      chk("wr_err", wr_err, m_err);
      chk("upd", upd, m);
      chk("sh_din", sh_din, din);
      if (ring_ok && !rst) chk("sh_dout", sh_dout, ring[m_slot]);
      if (rst) begin
         sb.delete();
         m_slot = 0;
         m_err = 0;
         if (clk_en) rcnt++;
         ring_ok = rcnt >= 24;
         if (ring_ok) foreach (ring[i]) ring[i] = '0;
      end else begin
         acc = wr_req && (sb.size() < 4 || m);
         m_err = acc && wr_slot >= 24;
         rcnt = 0;
         if (clk_en) ring[m_slot] = din;
         if (m) void'(sb.pop_front());
         if (acc && wr_slot < 24) sb.push_back('{wr_slot, wr_data});
         if (clk_en) m_slot = (m_slot + 1) % 24;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input int s, input int d);
      wr_req = 1'b1;
      wr_slot = 5'(s);
      wr_data = 5'(d);
      step(1);
      wr_req = 1'b0;
   endtask

   initial begin
      int n, k;
      step(1);
      go = 1;
      step(26);
      chk("rst_slot", slot, 0);
      chk("rst_zero", zero, 1);
      chk("rst_ready", wr_ready, 1);
      rst = 1'b0;
      // free-running slot sequence
      for (int i = 0; i < 50; i++) begin
         chk("seq_slot", slot, i % 24);
         chk("seq_zero", zero, (i % 24) == 0);
         step(1);
      end
      // single write at slot 9 aimed at slot 5
      for (int i = 0; i < 30 && m_slot != 9; i++) step(1);
      wr_req = 1'b1; wr_slot = 5'd5; wr_data = 5'h1A;
      n = 0;
      for (int i = 0; i < 40 && !upd; i++) begin
         step(1);
         wr_req = 1'b0;
         n++;
      end
      chk("ins_lat", n, 20);
      chk("ins_slot", slot, 5);
      step(60);
      // fill with clk_en low, refuse 5th, then drain in order
      clk_en = 1'b0;
      wr(3, 'h11); wr(3, 'h12); wr(7, 'h13); wr(2, 'h14);
      chk("full_ready", wr_ready, 0);
      wr(9, 'h15);
      chk("full_busy", busy, 1);
      step(3);
      clk_en = 1'b1;
      for (int i = 0; i < 200 && sb.size() > 0; i++) step(1);
      chk("drain_busy", busy, 0);
      step(30);
      // out-of-range slots
      wr(24, 'h01);
      chk("err_pulse", wr_err, 1);
      step(1);
      chk("err_gone", wr_err, 0);
      chk("err_busy", busy, 0);
      wr(31, 'h02);
      step(2);
      // full queue, matching head, simultaneous push
      clk_en = 1'b0;
      k = m_slot;
      wr(k, 'h05); wr((k + 2) % 24, 'h06); wr((k + 4) % 24, 'h07); wr((k + 6) % 24, 'h08);
      clk_en = 1'b1;
      wr((k + 8) % 24, 'h09);
      chk("swap_ready", wr_ready, 0);
      for (int i = 0; i < 200 && sb.size() > 0; i++) step(1);
      chk("swap_busy", busy, 0);
      step(30);
      // random traffic
      for (int i = 0; i < 300; i++) begin
         clk_en = 1'($urandom_range(0, 3) != 0);
         wr_req = 1'($urandom_range(0, 3) == 0);
         wr_slot = 5'($urandom_range(0, 26));
         wr_data = 5'($urandom);
         step(1);
      end
      wr_req = 1'b0;
      clk_en = 1'b1;
      step(30);
      // mid-operation reset with writes pending
      clk_en = 1'b0;
      wr(20, 'h1F); wr(21, 'h1E); wr(22, 'h1D);
      clk_en = 1'b1;
      rst = 1'b1;
      wr_req = 1'b1; wr_slot = 5'd1; wr_data = 5'h0C;
      step(24);
      wr_req = 1'b0;
      rst = 1'b0;
      chk("post_rst_busy", busy, 0);
      chk("post_rst_slot", slot, 0);
      for (int i = 0; i < 24; i++) begin
         chk("post_rst_line", sh_dout, 0);
         step(1);
      end
      step(5);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
